// File: rtl/fifo_rd_arbiter_pkg.sv
// Shared definitions for the FIFO read-port arbiter.
// - Default widths for consumer count, data width and burst limit.
// - FSM state encoding (idle = 1'b0, read = 1'b1).
package fifo_rd_arbiter_pkg;

  localparam int unsigned DefNcons    = 4;
  localparam int unsigned DefDw       = 8;
  localparam int unsigned DefMaxBurst = 4;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRead = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// Bundle of the FIFO read-side and consumer-side signals of the read arbiter.
// Ports (arbiter = master view):
//   emptyb   in   FIFO empty flag
//   rreqb    out  FIFO read request, one pop per cycle high
//   rdatb    in   FIFO read data, valid the cycle after rreqb
//   cons_req in   per-consumer level request
//   cons_gnt out  one-hot current owner, 0 when idle
//   cons_vld out  one-hot return-data valid
//   cons_dat out  returned word, zero unless |cons_vld
//   busy     out  high while a grant is active
interface fifo_rd_arbiter_if
  import fifo_rd_arbiter_pkg::*;
#(
  parameter int unsigned NCONS = DefNcons,
  parameter int unsigned DW    = DefDw
) ();

  logic             emptyb;
  logic             rreqb;
  logic [DW-1:0]    rdatb;
  logic [NCONS-1:0] cons_req;
  logic [NCONS-1:0] cons_gnt;
  logic [NCONS-1:0] cons_vld;
  logic [DW-1:0]    cons_dat;
  logic             busy;

  modport master (
    input  emptyb, rdatb, cons_req,
    output rreqb, cons_gnt, cons_vld, cons_dat, busy
  );

  modport slave (
    output emptyb, rdatb, cons_req,
    input  rreqb, cons_gnt, cons_vld, cons_dat, busy
  );

endinterface

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req    in   NCONS-bit request vector
//   ptr    in   index with highest priority this round
//   idx    out  index of the first set request at or above ptr, wrapping
//   onehot out  one-hot form of idx, all-zero when no request is set
module fifo_rd_arbiter_rr_pick
  import fifo_rd_arbiter_pkg::*;
#(
  parameter int unsigned NCONS = DefNcons
) (
  input  logic [NCONS-1:0]         req,
  input  logic [$clog2(NCONS)-1:0] ptr,
  output logic [$clog2(NCONS)-1:0] idx,
  output logic [NCONS-1:0]         onehot
);

  localparam int unsigned IW = $clog2(NCONS);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    idx    = '0;
    onehot = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned off = 0; off < NCONS; off++) begin
      cand = IW'((32'(ptr) + off) % NCONS);
      if (!found && req[cand]) begin
        found        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Shares the single read port of an async FIFO (read clock domain) among NCONS
// consumers with round-robin arbitration and bursts of at most MAX_BURST words.
// Each popped word is routed one cycle later to the consumer that won it.
// Ports:
//   clkb  in   read-domain clock, posedge
//   rstb  in   synchronous active-high reset
//   bus   master view of fifo_rd_arbiter_if (FIFO read side + consumer side)
module fifo_rd_arbiter
  import fifo_rd_arbiter_pkg::*;
#(
  parameter int unsigned NCONS     = DefNcons,
  parameter int unsigned DW        = DefDw,
  parameter int unsigned MAX_BURST = DefMaxBurst
) (
  input logic               clkb,
  input logic               rstb,
  fifo_rd_arbiter_if.master bus
);

  localparam int unsigned IW = $clog2(NCONS);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  arb_state_e       state_q;
  logic [IW-1:0]    rr_ptr_q;
  logic [IW-1:0]    owner_q;
  logic [CW-1:0]    burst_cnt_q;
  logic [NCONS-1:0] gnt_q;
  logic             busy_q;
  logic             vld_q;
  logic [IW-1:0]    idx_q;

  logic [IW-1:0]    pick_idx;
  logic [NCONS-1:0] pick_onehot;
  logic [IW-1:0]    next_ptr;
  logic             rreq;

  fifo_rd_arbiter_rr_pick #(
    .NCONS (NCONS)
  ) u_rr_pick (
    .req    (bus.cons_req),
    .ptr    (rr_ptr_q),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Owner drops to lowest priority for the next round.
  assign next_ptr = (owner_q == IW'(NCONS - 1)) ? '0 : owner_q + IW'(1);

  // Read is held off during reset so no word is popped that could not be delivered.
  assign rreq = !rstb && (state_q == StRead) && !bus.emptyb && bus.cons_req[owner_q] &&
                (burst_cnt_q < CW'(MAX_BURST));

  always_ff @(posedge clkb) begin
    if (rstb) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      vld_q       <= 1'b0;
      idx_q       <= '0;
    end else begin
      vld_q <= rreq;
      idx_q <= owner_q;
      case (state_q)
        StIdle: begin
          if (|bus.cons_req && !bus.emptyb) begin
            state_q     <= StRead;
            owner_q     <= pick_idx;
            gnt_q       <= pick_onehot;
            burst_cnt_q <= '0;
            busy_q      <= 1'b1;
          end
        end
        StRead: begin
          if (rreq) begin
            if (burst_cnt_q != CW'(MAX_BURST)) begin
              burst_cnt_q <= burst_cnt_q + CW'(1);
            end
          end else begin
            // Burst done, owner dropped, or FIFO empty: release and re-arbitrate.
            state_q  <= StIdle;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            rr_ptr_q <= next_ptr;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rreqb    = rreq;
  assign bus.cons_gnt = gnt_q;
  assign bus.busy     = busy_q;
  assign bus.cons_vld = vld_q ? ({{(NCONS - 1){1'b0}}, 1'b1} << idx_q) : '0;
  assign bus.cons_dat = vld_q ? bus.rdatb : {DW{1'b0}};

endmodule
